// File: rtl/seq_sched_pkg.sv
// -----------------------------------------------------------------------------
// seq_sched_pkg
// Shared constants and types for the time-multiplexed sequence recognizer.
//   - Default channel count, pattern length and target pattern.
//   - CH_W: channel index width for the default channel count.
//   - ctx_t: per-channel context (bit history + fill count) at default sizing.
//   - CNT_W and cnt_sat_inc(): match-counter width and saturating increment,
//     used only when MATCH_CNT_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package seq_sched_pkg;

    localparam int N_CH_DEF    = 4;
    localparam int PAT_LEN_DEF = 4;
    localparam logic [PAT_LEN_DEF-1:0] PATTERN_DEF = 4'b1011;

    localparam int CH_W   = $clog2(N_CH_DEF);
    localparam int FILL_W = $clog2(PAT_LEN_DEF);
    localparam int CNT_W  = 8;

    // Context saved per channel between grants.
    typedef struct packed {
        logic [PAT_LEN_DEF-2:0] hist;
        logic [FILL_W-1:0]      fill;
    } ctx_t;

    // Saturating increment for the per-channel match counters.
    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1'b1);
    endfunction

endpackage

// File: rtl/seq_recog_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. Grants the first eligible channel
// found searching upward from ptr with wrap-around. The pointer register is
// held by the parent.
//   eligible [N_CH]  : channels allowed to be granted this cycle
//   ptr      [IDX_W] : highest-priority channel this cycle
//   gnt      [N_CH]  : one-hot grant (all zero when nothing is eligible)
//   gnt_idx  [IDX_W] : binary index of the granted channel (0 when none)
//   gnt_any          : a grant was issued
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module rr_arbiter #(
    parameter  int N_CH  = 4,
    localparam int IDX_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  eligible,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_CH-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    int cand_i;

    // Rotating priority search starting at ptr; first hit wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand_i  = 0;
        for (int off = 0; off < N_CH; off++) begin
            cand_i = int'(ptr) + off;
            cand_i = (cand_i >= N_CH) ? (cand_i - N_CH) : cand_i;
            if (!gnt_any && eligible[cand_i]) begin
                gnt[cand_i] = 1'b1;
                gnt_idx     = IDX_W'(cand_i);
                gnt_any     = 1'b1;
            end else begin
                gnt_any = gnt_any;
            end
        end
    end

endmodule

// File: rtl/seq_recog_scheduler.sv
// -----------------------------------------------------------------------------
// seq_recog_scheduler
// One serial sequence recognizer shared by N_CH requesters. A round-robin
// arbiter picks one channel per cycle; that channel's saved history and fill
// count are combined with its input bit, checked against PATTERN and written
// back. Overlapping matches are reported; a fill guard suppresses matches
// until PAT_LEN bits have arrived since reset or flush.
//   clock, reset      : rising-edge clock, asynchronous active-high reset
//   req   [N_CH]      : per-channel request, held with x_in until granted
//   x_in  [N_CH]      : per-channel serial bit
//   flush [N_CH]      : per-channel context clear (blocks grant that cycle)
//   gnt   [N_CH]      : combinational one-hot grant
//   z_valid, z_ch, z  : registered result of last cycle's granted bit
// Optional build macro MATCH_CNT_EN adds per-channel 8-bit saturating match
// counters with a combinational read port (cnt_sel -> cnt_out).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module seq_recog_scheduler
    import seq_sched_pkg::*;
#(
    parameter  int                 N_CH    = N_CH_DEF,
    parameter  int                 PAT_LEN = PAT_LEN_DEF,
    parameter  logic [PAT_LEN-1:0] PATTERN = PATTERN_DEF,
    localparam int                 IDX_W   = $clog2(N_CH),
    localparam int                 HIST_W  = PAT_LEN - 1,
    localparam int                 FW      = $clog2(PAT_LEN)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_CH-1:0]  req,
    input  logic [N_CH-1:0]  x_in,
    input  logic [N_CH-1:0]  flush,
`ifdef MATCH_CNT_EN
    input  logic [IDX_W-1:0] cnt_sel,
    output logic [CNT_W-1:0] cnt_out,
`endif
    output logic [N_CH-1:0]  gnt,
    output logic             z_valid,
    output logic [IDX_W-1:0] z_ch,
    output logic             z
);

    localparam logic [FW-1:0] FILL_MAX = FW'(PAT_LEN - 1);

    logic [N_CH-1:0]   eligible;
    logic [N_CH-1:0]   arb_gnt;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_any;
    logic [PAT_LEN-1:0] cand;

    logic [IDX_W-1:0]  rr_ptr_q,  rr_ptr_d;
    logic              z_valid_q, z_valid_d;
    logic              z_q,       z_d;
    logic [IDX_W-1:0]  z_ch_q,    z_ch_d;
    logic [HIST_W-1:0] hist_q [N_CH];
    logic [HIST_W-1:0] hist_d [N_CH];
    logic [FW-1:0]     fill_q [N_CH];
    logic [FW-1:0]     fill_d [N_CH];
`ifdef MATCH_CNT_EN
    logic [CNT_W-1:0]  cnt_q  [N_CH];
    logic [CNT_W-1:0]  cnt_d  [N_CH];
`endif

    // A flushing channel is not eligible so its pending bit survives the flush.
    always_comb begin
        eligible = req & ~flush;
    end

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .eligible (eligible),
        .ptr      (rr_ptr_q),
        .gnt      (arb_gnt),
        .gnt_idx  (arb_idx),
        .gnt_any  (arb_any)
    );

    // Grant is forced low while reset is held.
    always_comb begin
        if (reset) begin
            gnt = '0;
        end else begin
            gnt = arb_gnt;
        end
    end

    // Context update and match detection for the granted channel, then flushes.
    always_comb begin
        hist_d    = hist_q;
        fill_d    = fill_q;
        rr_ptr_d  = rr_ptr_q;
        z_valid_d = 1'b0;
        z_d       = 1'b0;
        z_ch_d    = z_ch_q;
        cand      = '0;
`ifdef MATCH_CNT_EN
        cnt_d     = cnt_q;
`endif
        if (arb_any) begin
            cand              = {hist_q[arb_idx], x_in[arb_idx]};
            z_d               = (cand == PATTERN) && (fill_q[arb_idx] == FILL_MAX);
            hist_d[arb_idx]   = cand[HIST_W-1:0];
            z_valid_d         = 1'b1;
            z_ch_d            = arb_idx;
            if (fill_q[arb_idx] == FILL_MAX) begin
                fill_d[arb_idx] = FILL_MAX;
            end else begin
                fill_d[arb_idx] = fill_q[arb_idx] + FW'(1'b1);
            end
            if (arb_idx == IDX_W'(N_CH - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = arb_idx + IDX_W'(1'b1);
            end
`ifdef MATCH_CNT_EN
            if (z_d) begin
                cnt_d[arb_idx] = cnt_sat_inc(cnt_q[arb_idx]);
            end else begin
                cnt_d[arb_idx] = cnt_q[arb_idx];
            end
`endif
        end else begin
            z_ch_d = z_ch_q;
        end
        // A flushed channel is never the granted one, so this cannot clobber
        // the update above.
        for (int i = 0; i < N_CH; i++) begin
            if (flush[i]) begin
                hist_d[i] = '0;
                fill_d[i] = '0;
`ifdef MATCH_CNT_EN
                cnt_d[i]  = '0;
`endif
            end else begin
                hist_d[i] = hist_d[i];
            end
        end
    end

    // State registers: pointer, result outputs and per-channel contexts.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_q  <= '0;
            z_valid_q <= 1'b0;
            z_q       <= 1'b0;
            z_ch_q    <= '0;
            for (int i = 0; i < N_CH; i++) begin
                hist_q[i] <= '0;
                fill_q[i] <= '0;
`ifdef MATCH_CNT_EN
                cnt_q[i]  <= '0;
`endif
            end
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            z_valid_q <= z_valid_d;
            z_q       <= z_d;
            z_ch_q    <= z_ch_d;
            for (int i = 0; i < N_CH; i++) begin
                hist_q[i] <= hist_d[i];
                fill_q[i] <= fill_d[i];
`ifdef MATCH_CNT_EN
                cnt_q[i]  <= cnt_d[i];
`endif
            end
        end
    end

    // Registered outputs.
    always_comb begin
        z_valid = z_valid_q;
        z       = z_q;
        z_ch    = z_ch_q;
`ifdef MATCH_CNT_EN
        cnt_out = cnt_q[cnt_sel];
`endif
    end

endmodule

// File: tb/tb_seq_recog_scheduler.sv
// -----------------------------------------------------------------------------
// tb_seq_recog_scheduler
// Table-driven bench for seq_recog_scheduler at default parameters
// (N_CH=4, PAT_LEN=4, PATTERN=1011). Each row drives one cycle, checks the
// combinational grant, queues the expected registered result and compares it
// after the edge. Hand-written sequences cover reset state, mid-run reset and
// (with MATCH_CNT_EN) the match counters.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seq_recog_scheduler;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] req, x_in, flush, gnt;
    logic       z_valid, z;
    logic [1:0] z_ch;
`ifdef MATCH_CNT_EN
    logic [1:0] cnt_sel;
    logic [7:0] cnt_out;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] x;
        logic [3:0] fl;
        logic [3:0] gnt;
        logic       zv;
        logic       z;
        logic [1:0] zch;
    } vec_t;

    typedef struct {
        logic       zv;
        logic       z;
        logic [1:0] zch;
        int         tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    seq_recog_scheduler dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .x_in    (x_in),
        .flush   (flush),
`ifdef MATCH_CNT_EN
        .cnt_sel (cnt_sel),
        .cnt_out (cnt_out),
`endif
        .gnt     (gnt),
        .z_valid (z_valid),
        .z_ch    (z_ch),
        .z       (z)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] r, input logic [3:0] x, input logic [3:0] f,
                                input logic [3:0] g, input logic zv, input logic zz,
                                input logic [1:0] zc);
        vec_t v;
        v.req = r; v.x = x; v.fl = f; v.gnt = g; v.zv = zv; v.z = zz; v.zch = zc;
        return v;
    endfunction

    // Called at posedge+1: drive, check grant, cross edge, check result.
    task automatic step(input vec_t v, input int tag);
        exp_t e;
        req   = v.req;
        x_in  = v.x;
        flush = v.fl;
        #2;
        chk($sformatf("gnt[%0d]", tag), 32'(gnt), 32'(v.gnt));
        e.zv = v.zv; e.z = v.z; e.zch = v.zch; e.tag = tag;
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            chk($sformatf("sb_empty[%0d]", tag), 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk($sformatf("z_valid[%0d]", e.tag), 32'(z_valid), 32'(e.zv));
            chk($sformatf("z[%0d]", e.tag), 32'(z), 32'(e.z));
            if (e.zv) begin
                chk($sformatf("z_ch[%0d]", e.tag), 32'(z_ch), 32'(e.zch));
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        x_in  = 4'b0000;
        flush = 4'b0000;
`ifdef MATCH_CNT_EN
        cnt_sel = 2'd0;
`endif
        // Round robin from reset, then flush everything.
        for (int r = 0; r < 2; r++) begin
            vecs.push_back(mk(4'hF, 4'h0, 4'h0, 4'h1, 1'b1, 1'b0, 2'd0));
            vecs.push_back(mk(4'hF, 4'h0, 4'h0, 4'h2, 1'b1, 1'b0, 2'd1));
            vecs.push_back(mk(4'hF, 4'h0, 4'h0, 4'h4, 1'b1, 1'b0, 2'd2));
            vecs.push_back(mk(4'hF, 4'h0, 4'h0, 4'h8, 1'b1, 1'b0, 2'd3));
        end
        vecs.push_back(mk(4'h0, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0, 2'd0));
        // Single channel ch0: 1,0,1,1 then idle.
        vecs.push_back(mk(4'h1, 4'h1, 4'h0, 4'h1, 1'b1, 1'b0, 2'd0));
        vecs.push_back(mk(4'h1, 4'h0, 4'h0, 4'h1, 1'b1, 1'b0, 2'd0));
        vecs.push_back(mk(4'h1, 4'h1, 4'h0, 4'h1, 1'b1, 1'b0, 2'd0));
        vecs.push_back(mk(4'h1, 4'h1, 4'h0, 4'h1, 1'b1, 1'b1, 2'd0));
        vecs.push_back(mk(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0));
        // Overlap on ch2: 1011011 -> matches on bits 4 and 7.
        vecs.push_back(mk(4'h4, 4'h4, 4'h0, 4'h4, 1'b1, 1'b0, 2'd2));
        vecs.push_back(mk(4'h4, 4'h0, 4'h0, 4'h4, 1'b1, 1'b0, 2'd2));
        vecs.push_back(mk(4'h4, 4'h4, 4'h0, 4'h4, 1'b1, 1'b0, 2'd2));
        vecs.push_back(mk(4'h4, 4'h4, 4'h0, 4'h4, 1'b1, 1'b1, 2'd2));
        vecs.push_back(mk(4'h4, 4'h0, 4'h0, 4'h4, 1'b1, 1'b0, 2'd2));
        vecs.push_back(mk(4'h4, 4'h4, 4'h0, 4'h4, 1'b1, 1'b0, 2'd2));
        vecs.push_back(mk(4'h4, 4'h4, 4'h0, 4'h4, 1'b1, 1'b1, 2'd2));
        // Interleave ch1/ch3, each streaming 1011 (ptr starts at 3).
        vecs.push_back(mk(4'hA, 4'hA, 4'h0, 4'h8, 1'b1, 1'b0, 2'd3));
        vecs.push_back(mk(4'hA, 4'h2, 4'h0, 4'h2, 1'b1, 1'b0, 2'd1));
        vecs.push_back(mk(4'hA, 4'h0, 4'h0, 4'h8, 1'b1, 1'b0, 2'd3));
        vecs.push_back(mk(4'hA, 4'h8, 4'h0, 4'h2, 1'b1, 1'b0, 2'd1));
        vecs.push_back(mk(4'hA, 4'hA, 4'h0, 4'h8, 1'b1, 1'b0, 2'd3));
        vecs.push_back(mk(4'hA, 4'hA, 4'h0, 4'h2, 1'b1, 1'b0, 2'd1));
        vecs.push_back(mk(4'hA, 4'hA, 4'h0, 4'h8, 1'b1, 1'b1, 2'd3));
        vecs.push_back(mk(4'h2, 4'h2, 4'h0, 4'h2, 1'b1, 1'b1, 2'd1));
        // ch1 sends 10, ch3 sends 11 interleaved: no match.
        vecs.push_back(mk(4'hA, 4'hA, 4'h0, 4'h8, 1'b1, 1'b0, 2'd3));
        vecs.push_back(mk(4'hA, 4'hA, 4'h0, 4'h2, 1'b1, 1'b0, 2'd1));
        vecs.push_back(mk(4'hA, 4'h8, 4'h0, 4'h8, 1'b1, 1'b0, 2'd3));
        vecs.push_back(mk(4'h2, 4'h0, 4'h0, 4'h2, 1'b1, 1'b0, 2'd1));
        // Flush on ch0 mid-pattern (plus an unrelated flush on ch2).
        vecs.push_back(mk(4'h1, 4'h1, 4'h0, 4'h1, 1'b1, 1'b0, 2'd0));
        vecs.push_back(mk(4'h1, 4'h0, 4'h4, 4'h1, 1'b1, 1'b0, 2'd0));
        vecs.push_back(mk(4'h1, 4'h1, 4'h0, 4'h1, 1'b1, 1'b0, 2'd0));
        vecs.push_back(mk(4'h1, 4'h1, 4'h1, 4'h0, 1'b0, 1'b0, 2'd0));
        vecs.push_back(mk(4'h1, 4'h1, 4'h0, 4'h1, 1'b1, 1'b0, 2'd0));
        vecs.push_back(mk(4'h1, 4'h1, 4'h0, 4'h1, 1'b1, 1'b0, 2'd0));
        vecs.push_back(mk(4'h1, 4'h0, 4'h0, 4'h1, 1'b1, 1'b0, 2'd0));
        vecs.push_back(mk(4'h1, 4'h1, 4'h0, 4'h1, 1'b1, 1'b0, 2'd0));
        vecs.push_back(mk(4'h1, 4'h1, 4'h0, 4'h1, 1'b1, 1'b1, 2'd0));

        // Reset state, grant held low while reset is high.
        repeat (2) @(posedge clock);
        #1;
        req = 4'hF;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_z_valid", 32'(z_valid), 32'd0);
        chk("rst_z", 32'(z), 32'd0);
        chk("rst_z_ch", 32'(z_ch), 32'd0);
        req   = 4'h0;
        reset = 1'b0;
        @(posedge clock);
        #1;

        foreach (vecs[i]) begin
            step(vecs[i], i);
        end

`ifdef MATCH_CNT_EN
        cnt_sel = 2'd0;
        #1;
        chk("cnt_ch0", 32'(cnt_out), 32'd1);
        cnt_sel = 2'd1;
        #1;
        chk("cnt_ch1", 32'(cnt_out), 32'd1);
        cnt_sel = 2'd2;
        #1;
        chk("cnt_ch2", 32'(cnt_out), 32'd0);
        cnt_sel = 2'd0;
        step(mk(4'h0, 4'h0, 4'h1, 4'h0, 1'b0, 1'b0, 2'd0), 200);
        chk("cnt_ch0_flushed", 32'(cnt_out), 32'd0);
`endif

        // ch0 builds 101, ch1 granted, then reset mid-cycle.
        step(mk(4'h1, 4'h1, 4'h0, 4'h1, 1'b1, 1'b0, 2'd0), 300);
        step(mk(4'h1, 4'h0, 4'h0, 4'h1, 1'b1, 1'b0, 2'd0), 301);
        step(mk(4'h1, 4'h1, 4'h0, 4'h1, 1'b1, 1'b0, 2'd0), 302);
        step(mk(4'hF, 4'hF, 4'h0, 4'h2, 1'b1, 1'b0, 2'd1), 303);
        req  = 4'hF;
        x_in = 4'hF;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_z_valid", 32'(z_valid), 32'd0);
        chk("mid_rst_z", 32'(z), 32'd0);
        chk("mid_rst_z_ch", 32'(z_ch), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        // Restart from ch0; its history was cleared so 1 does not complete 1011.
        step(mk(4'hF, 4'hF, 4'h0, 4'h1, 1'b1, 1'b0, 2'd0), 310);
        step(mk(4'hF, 4'hF, 4'h0, 4'h2, 1'b1, 1'b0, 2'd1), 311);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_recog_scheduler.md
Name: seq_recog_scheduler

Overview:
Time-multiplexes one serial sequence-recognition datapath across N_CH independent serial requesters. Each requester presents one bit per request. A round-robin scheduler grants one channel per cycle. Per-channel context (bit history and fill count) is saved and restored so every channel is recognized independently. The block sits between the serial bit sources and downstream match consumers, replacing N_CH separate recognizer instances.

Parameters:
N_CH, 4, number of requester channels (2..16)
PAT_LEN, 4, pattern length in bits (2..8)
PATTERN, 4'b1011, target sequence, MSB received first; overlapping matches count

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  N_CH  per-channel request; channel holds req and x_in stable until granted
x_in  input  N_CH  per-channel serial data bit
flush  input  N_CH  per-channel pulse; clears that channel's context
gnt  output  N_CH  one-hot grant, combinational from req, flush and pointer; bit consumed on the edge where req[i]&gnt[i]
z_valid  output  1  registered; a granted bit was processed last cycle
z_ch  output  clog2(N_CH)  registered; channel processed last cycle
z  output  1  registered; 1 when the processed bit completed PATTERN on z_ch

Behaviour:
- Reset (async, active-high):
  - z_valid=0, z=0, z_ch=0, rr_ptr=0.
  - All histories=0, all fill counts=0.
  - gnt=0 while reset is high.
- Eligibility: eligible[i] = req[i] & ~flush[i].
- Arbitration:
  - Grant the first eligible channel searching from rr_ptr upward with wrap.
  - No eligible channel: gnt=0.
  - On a grant to channel k: rr_ptr <= (k+1) mod N_CH.
  - No grant: rr_ptr holds.
- Datapath on grant to channel k, all updates at the edge:
  - cand = {hist[k], x_in[k]} (PAT_LEN bits).
  - z <= (cand==PATTERN) && (fill[k] >= PAT_LEN-1).
  - hist[k] <= cand[PAT_LEN-2:0].
  - fill[k] saturates at PAT_LEN-1.
  - z_valid <= 1, z_ch <= k.
- No grant: z_valid <= 0, z <= 0, z_ch holds.
- Latency: match reported exactly 1 cycle after the granting edge.
- Throughput: 1 bit per cycle aggregate. Each channel is guaranteed service within N_CH cycles when continuously requesting.
- Overlap: history is not cleared on a match. For 1011011, matches occur at bits 4 and 7.
- Flush:
  - flush[k] clears hist[k] and fill[k] at the edge.
  - If req[k] is also high that cycle, no grant goes to k; the bit stays pending.
  - Flush on a non-granted channel does not disturb the granted channel.
- Fill guard: no match until PAT_LEN bits have been received since reset or flush. This prevents a false match on a zero-prefixed PATTERN.
- Reset mid-operation: all state is cleared immediately and no partial match survives. After reset deasserts, arbitration restarts from channel 0.
- Contexts are fully independent; interleaving never mixes histories.

Optional Feature:
MATCH_CNT_EN
- When defined:
  - Per-channel 8-bit saturating match counter, incremented when z is registered high for that channel.
  - Cleared by reset or by that channel's flush.
  - Added ports: cnt_sel input clog2(N_CH); cnt_out output 8, combinational read of counter[cnt_sel].
  - Saturates at 255.
- When undefined: counters and both ports are absent; all other behaviour is identical.

Decomposition:
- Package seq_sched_pkg:
  - CH_W = clog2(N_CH) constant.
  - Default N_CH, PAT_LEN and PATTERN constants.
  - Context struct typedef: hist[PAT_LEN-1], fill[clog2(PAT_LEN)].
  - Match-counter width constant (8).
- Sub-module rr_arbiter (N_CH): inputs eligible and ptr; outputs one-hot gnt and granted index. Purely combinational; the pointer register lives in the parent.
- Context array and match logic stay in seq_recog_scheduler.

Test Plan:
- Reset check: assert reset mid-run → z_valid=0, z=0, z_ch=0, gnt=0 immediately; after release, req=4'b1111 gives first gnt=4'b0001.
- Single channel: ch0 sends 1,0,1,1 on consecutive grants → z=1, z_ch=0 one cycle after the 4th grant; z=0 after grants 1–3.
- Overlap: ch2 sends 1,0,1,1,0,1,1 → z=1 after bits 4 and 7 only.
- Round-robin: req=4'b1111 held for 8 cycles → gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000; z_ch follows 0,1,2,3,... lagging by 1 cycle.
- Interleave isolation: ch1 and ch3 each stream 1011 alternately → two matches, z_ch=1 and z_ch=3; ch1 sending 10 and ch3 sending 11 yields no match.
- Flush: ch0 sends 1,0,1, then flush[0]=1 with req[0]=1 (no gnt to ch0), then 1 → no match. Repeating 1,0,1,1 afterwards → match. With MATCH_CNT_EN: cnt_out for ch0 = 1, and 0 after a second flush.
